ps2_key_gen: RTL and testbench
==============================

Name: ps2_key_gen

Overview:
- Producer end of the 11-bit ps2_key event word that hps_io hands to each core's keyboard decoder.
- Receives raw PS/2 keyboard frames on the clock/data lines and strips E0/F0/E1 prefixes.
- Publishes one toggle-qualified event per key make or break: {toggle, pressed, extended, code[7:0]}.
- Sits between the PS/2 pins (or user port) and the core's key-decode logic, in the clk_sys domain.

Parameters:
- FILT_LEN, 8: consecutive clk_sys samples that must agree before the filtered ps2_clk changes level.
- TIMEOUT, 20000: clk_sys cycles with no falling edge mid-frame before the frame is aborted.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk_sys.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk_sys.
- ps2_key  out  11  [10] toggles per event, [9] pressed, [8] extended (E0), [7:0] scancode.
- key_strobe  out  1  one-cycle pulse in the same cycle ps2_key updates.
- frame_err  out  1  one-cycle pulse on a bad start bit, bad stop bit, parity error (see feature) or timeout.

Behaviour:
- Clock/reset: one clock, clk_sys. RESET is asynchronous and active-high.
- Reset values: ps2_key=0, key_strobe=0, frame_err=0, filtered clk=1, bit counter=0, decoder in IDLE with ext=brk=0 and skip=0.
- Synchronisers: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clk changes only after FILT_LEN equal consecutive synced samples.
  - A fall is detected when the filtered clk goes 1->0.
- Frame receiver (bit counter 0..10), on each falling edge:
  - bit0 must be 0, else frame_err pulses and the counter stays 0.
  - bits 1..8 are data, LSB first. bit9 is parity. bit10 is the stop bit.
  - At bit10: stop bit=1 means a valid byte is presented to the decoder for one cycle. Stop bit=0 pulses frame_err and drops the byte. Either way the counter returns to 0.
- Watchdog: counts cycles since the last fall while the counter is nonzero. When it reaches TIMEOUT, the counter is set to 0 and frame_err pulses. It is idle when the counter is 0.
- Decoder FSM, states IDLE / PREFIX / SKIP:
  - E0 sets ext=1 and goes to PREFIX.
  - F0 sets brk=1 and goes to PREFIX. The order of E0 and F0 is free (E0 F0 xx).
  - E1 in IDLE sets skip=7 and goes to SKIP. Each byte in SKIP decrements skip. At 0 the decoder returns to IDLE and no event is emitted (Pause is dropped).
  - Any other byte emits one event and returns to IDLE, clearing ext and brk:
    - ps2_key <= {~ps2_key[10], ~brk, ext, byte}
    - key_strobe=1 for one cycle
  - In IDLE only, bytes AA, FA, FE, EE, 00 and FF are discarded silently. After a prefix they are emitted normally (e.g. E0 F0 AA is a valid event).
- Latency: the event appears 1 clk_sys cycle after the cycle the stop bit is sampled. Bytes are serialised by the line, so no queueing is needed.
- A frame error while in PREFIX or SKIP returns the decoder to IDLE and clears ext, brk and skip.
- Reset mid-frame: all state returns to reset values. The partial frame is lost and ps2_key[10] restarts at 0.

Optional Feature:
- Macro PS2_KEY_PARITY_CHECK_EN.
- Defined: bit9 must make the 9 bits (data+parity) odd parity. On mismatch the byte is dropped at bit10 and frame_err pulses.
- Undefined: bit9 is ignored. Only the start, stop and timeout checks raise frame_err.

Decomposition:
- Package ps2_key_pkg holds:
  - localparams for the prefix bytes (E0, F0, E1) and the discard set.
  - the decoder state enum.
  - the ps2_key field bit positions (TOGGLE=10, PRESSED=9, EXT=8).
- One sub-module, ps2_frame_rx, covers the synchronisers, filter, bit counter, watchdog and parity. It outputs byte[7:0], byte_valid and frame_err.
- ps2_key_gen instantiates ps2_frame_rx plus the decoder FSM.

Test Plan:
- Frame 0x1C (A) after reset -> ps2_key=0x61C (toggle=1, pressed=1, ext=0), key_strobe high 1 cycle.
- Frames F0,1C following it -> ps2_key=0x01C (toggle=0, pressed=0), exactly one strobe.
- Frames E0,75 then E0,F0,75 -> first 0x775, then 0x175.
- Frames E1,14,77,E1,F0,14,F0,77 then 0x29 -> no event for Pause, then ps2_key toggle flips with code 0x29 and pressed=1.
- Glitches and timeout:
  - ps2_clk glitch low for FILT_LEN-1 cycles mid-frame -> no extra bit counted.
  - Stall after 4 bits for TIMEOUT cycles -> frame_err pulse, and the next full frame 0x1C decodes correctly.
  - Corrupted parity -> with PS2_KEY_PARITY_CHECK_EN: frame_err, no event. Without it: event emitted.
- Idle noise and reset:
  - Idle frames AA and FA -> no strobe, ps2_key unchanged.
  - RESET asserted between bit 5 and bit 6 -> outputs 0 immediately, and the next clean frame decodes.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants, decoder state type and ps2_key field positions for the PS/2 key generator.
package ps2_key_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Pause sends E1 followed by seven bytes that carry no key of their own
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    SKIP
  } dec_state_t;

  // Keyboard housekeeping replies, ignored only when no prefix is pending
  function automatic logic is_idle_noise(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_gen_if.sv
// PS/2 pin inputs and ps2_key event outputs bundled between the generator and its consumer.
interface ps2_key_gen_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output key_strobe,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  key_strobe,
    input  frame_err
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, 11-bit framing and mid-frame watchdog.
// Odd-parity checking is compiled in only when PS2_KEY_PARITY_CHECK_EN is defined.
module ps2_frame_rx #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          fall;
  logic          data_bit;
  logic          parity_ok;

  assign data_bit = data_sync_q[1];
  assign rx_byte  = shift_q;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = filt_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wd_cnt_d    = wd_cnt_q;
    fall        = 1'b0;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;

    // The filtered clock flips only after FILT_LEN disagreeing samples in a row
    if (clk_sync_q[1] == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
      filt_clk_d = ~filt_clk_q;
      filt_cnt_d = '0;
      fall       = filt_clk_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    if (bit_cnt_q == 4'd0 || fall) wd_cnt_d = '0;
    else                           wd_cnt_d = wd_cnt_q + 1'b1;

    if (fall) begin
      case (bit_cnt_q)
        4'd0: begin
          if (!data_bit) bit_cnt_d = 4'd1;
          else           frame_err = 1'b1;
        end
        4'd9: bit_cnt_d = 4'd10;
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (data_bit && parity_ok) byte_valid = 1'b1;
          else                       frame_err  = 1'b1;
        end
        default: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0 && wd_cnt_q == WW'(TIMEOUT - 1)) begin
      bit_cnt_d = 4'd0;
      wd_cnt_d  = '0;
      frame_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wd_cnt_q    <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

`ifdef PS2_KEY_PARITY_CHECK_EN
  logic par_q, par_d;

  // Running XOR over data and parity bits; odd parity leaves it at 1
  always_comb begin
    par_d = par_q;
    if (fall) begin
      if (bit_cnt_q == 4'd0)       par_d = 1'b0;
      else if (bit_cnt_q <= 4'd9)  par_d = par_q ^ data_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign parity_ok = par_q;
`else
  assign parity_ok = 1'b1;
`endif

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard to ps2_key event word: frame receiver plus E0/F0/E1 prefix-stripping decoder.
// Define PS2_KEY_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_gen
  import ps2_key_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 20000
) (
  input  logic          clk_sys,
  input  logic          RESET,
  ps2_key_gen_if.master bus
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_err;

  dec_state_t  state_q;
  logic        ext_q;
  logic        brk_q;
  logic [2:0]  skip_q;
  logic [10:0] key_q;
  logic        strobe_q;
  logic        err_q;

  ps2_frame_rx #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_rx (
    .clk        (clk_sys),
    .rst        (RESET),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  // A broken frame abandons any prefix or Pause sequence in progress
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= rx_err;
      if (rx_err) begin
        state_q <= IDLE;
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
        skip_q  <= '0;
      end else if (rx_valid) begin
        case (state_q)
          SKIP: begin
            skip_q <= skip_q - 3'd1;
            if (skip_q == 3'd1) state_q <= IDLE;
          end
          default: begin
            if (rx_byte == PFX_EXT) begin
              ext_q   <= 1'b1;
              state_q <= PREFIX;
            end else if (rx_byte == PFX_BRK) begin
              brk_q   <= 1'b1;
              state_q <= PREFIX;
            end else if (state_q == IDLE && rx_byte == PFX_PAUSE) begin
              skip_q  <= PAUSE_SKIP;
              state_q <= SKIP;
            end else if (!(state_q == IDLE && is_idle_noise(rx_byte))) begin
              key_q[KEY_TOGGLE]  <= ~key_q[KEY_TOGGLE];
              key_q[KEY_PRESSED] <= ~brk_q;
              key_q[KEY_EXT]     <= ext_q;
              key_q[7:0]         <= rx_byte;
              strobe_q           <= 1'b1;
              ext_q              <= 1'b0;
              brk_q              <= 1'b0;
              state_q            <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.ps2_key    = key_q;
  assign bus.key_strobe = strobe_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: sends PS/2 frames and checks the ps2_key events and error pulses.
module tb_ps2_key_gen;

  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 2000;
  localparam int HALF     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   strobe_cnt = 0;
  int   err_cnt = 0;
  int   s0, e0;

  always #5 clk = ~clk;

  ps2_key_gen_if bus ();

  ps2_key_gen #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_sys (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  // Every one-cycle pulse is seen exactly once on the falling edge
  always @(negedge clk) begin
    if (bus.key_strobe === 1'b1) strobe_cnt++;
    if (bus.frame_err === 1'b1)  err_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    bus.ps2_data = b;
    idle(HALF);
    bus.ps2_clk = 1'b0;
    idle(HALF);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      idle(12);
      bus.ps2_clk = 1'b0;
      idle(FILT_LEN - 1);
      bus.ps2_clk = 1'b1;
      idle(HALF);
    end else begin
      idle(HALF);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_bit);
    logic par;
    par = (~^b) ^ bad_par;
    send_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1);
    send_bit(par, glitch_bit == 9);
    send_bit(~bad_stop, glitch_bit == 10);
  endtask

  task automatic mark();
    s0 = strobe_cnt;
    e0 = err_cnt;
  endtask

  task automatic test_reset();
    idle(3);
    vectors++;
    if (bus.ps2_key !== 11'h000) begin miscompares++; $display("[TB] FAIL reset_key got %h expected 000", bus.ps2_key); end
    vectors++;
    if (bus.key_strobe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobe got %b expected 0", bus.key_strobe); end
    vectors++;
    if (bus.frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b expected 0", bus.frame_err); end
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_make();
    mark();
    send_frame(8'h1C, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h61C) begin miscompares++; $display("[TB] FAIL make_key got %h expected 61C", bus.ps2_key); end
    vectors++;
    if (strobe_cnt - s0 !== 1) begin miscompares++; $display("[TB] FAIL make_strobes got %0d expected 1", strobe_cnt - s0); end
  endtask

  task automatic test_break();
    mark();
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1C, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h01C) begin miscompares++; $display("[TB] FAIL break_key got %h expected 01C", bus.ps2_key); end
    vectors++;
    if (strobe_cnt - s0 !== 1) begin miscompares++; $display("[TB] FAIL break_strobes got %0d expected 1", strobe_cnt - s0); end
  endtask

  task automatic test_extended();
    mark();
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h775) begin miscompares++; $display("[TB] FAIL ext_make_key got %h expected 775", bus.ps2_key); end
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h175) begin miscompares++; $display("[TB] FAIL ext_break_key got %h expected 175", bus.ps2_key); end
    vectors++;
    if (strobe_cnt - s0 !== 2) begin miscompares++; $display("[TB] FAIL ext_strobes got %0d expected 2", strobe_cnt - s0); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    mark();
    for (int i = 0; i < 8; i++) send_frame(seq[i], 0, 0, -1);
    vectors++;
    if (strobe_cnt - s0 !== 0) begin miscompares++; $display("[TB] FAIL pause_strobes got %0d expected 0", strobe_cnt - s0); end
    vectors++;
    if (bus.ps2_key !== 11'h175) begin miscompares++; $display("[TB] FAIL pause_key got %h expected 175", bus.ps2_key); end
    send_frame(8'h29, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h629) begin miscompares++; $display("[TB] FAIL after_pause_key got %h expected 629", bus.ps2_key); end
  endtask

  task automatic test_idle_noise();
    logic [7:0] noise [4];
    noise = '{8'hAA, 8'hFA, 8'h00, 8'hFF};
    mark();
    for (int i = 0; i < 4; i++) send_frame(noise[i], 0, 0, -1);
    vectors++;
    if (strobe_cnt - s0 !== 0) begin miscompares++; $display("[TB] FAIL noise_strobes got %0d expected 0", strobe_cnt - s0); end
    vectors++;
    if (bus.ps2_key !== 11'h629) begin miscompares++; $display("[TB] FAIL noise_key got %h expected 629", bus.ps2_key); end
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'hAA, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h1AA) begin miscompares++; $display("[TB] FAIL prefixed_aa_key got %h expected 1AA", bus.ps2_key); end
  endtask

  task automatic test_bad_framing();
    mark();
    send_bit(1'b1, 0);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("[TB] FAIL bad_start_err got %0d expected 1", err_cnt - e0); end
    mark();
    send_frame(8'h1C, 0, 1, -1);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("[TB] FAIL bad_stop_err got %0d expected 1", err_cnt - e0); end
    vectors++;
    if (strobe_cnt - s0 !== 0 || bus.ps2_key !== 11'h1AA) begin
      miscompares++;
      $display("[TB] FAIL bad_stop_drop strobes %0d key %h expected 0 and 1AA", strobe_cnt - s0, bus.ps2_key);
    end
  endtask

  task automatic test_prefix_abort();
    mark();
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'h75, 0, 1, -1);
    send_frame(8'h1C, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h61C) begin miscompares++; $display("[TB] FAIL prefix_abort_key got %h expected 61C", bus.ps2_key); end
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("[TB] FAIL prefix_abort_err got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_glitch();
    mark();
    send_frame(8'h1C, 0, 0, 4);
    vectors++;
    if (bus.ps2_key !== 11'h21C) begin miscompares++; $display("[TB] FAIL glitch_key got %h expected 21C", bus.ps2_key); end
    vectors++;
    if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_counts strobes %0d errs %0d expected 1 and 0", strobe_cnt - s0, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    mark();
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    idle(TIMEOUT + 100);
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("[TB] FAIL timeout_err got %0d expected 1", err_cnt - e0); end
    vectors++;
    if (strobe_cnt - s0 !== 0) begin miscompares++; $display("[TB] FAIL timeout_strobes got %0d expected 0", strobe_cnt - s0); end
    send_frame(8'h1C, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h61C) begin miscompares++; $display("[TB] FAIL after_timeout_key got %h expected 61C", bus.ps2_key); end
  endtask

  task automatic test_parity();
    mark();
    send_frame(8'h1C, 1, 0, -1);
`ifdef PS2_KEY_PARITY_CHECK_EN
    vectors++;
    if (err_cnt - e0 !== 1 || strobe_cnt - s0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL parity_counts errs %0d strobes %0d expected 1 and 0", err_cnt - e0, strobe_cnt - s0);
    end
    vectors++;
    if (bus.ps2_key !== 11'h61C) begin miscompares++; $display("[TB] FAIL parity_key got %h expected 61C", bus.ps2_key); end
`else
    vectors++;
    if (err_cnt - e0 !== 0 || strobe_cnt - s0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL parity_counts errs %0d strobes %0d expected 0 and 1", err_cnt - e0, strobe_cnt - s0);
    end
    vectors++;
    if (bus.ps2_key !== 11'h21C) begin miscompares++; $display("[TB] FAIL parity_key got %h expected 21C", bus.ps2_key); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.ps2_key !== 11'h000 || bus.key_strobe !== 1'b0 || bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset outputs key %h strobe %b err %b expected 000 0 0", bus.ps2_key, bus.key_strobe, bus.frame_err);
    end
    idle(4);
    rst = 1'b0;
    idle(20);
    mark();
    send_frame(8'h1C, 0, 0, -1);
    vectors++;
    if (bus.ps2_key !== 11'h61C) begin miscompares++; $display("[TB] FAIL post_reset_key got %h expected 61C", bus.ps2_key); end
    vectors++;
    if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_counts strobes %0d errs %0d expected 1 and 0", strobe_cnt - s0, err_cnt - e0);
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_pause();
    test_idle_noise();
    test_bad_framing();
    test_prefix_abort();
    test_glitch();
    test_timeout();
    test_parity();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
